alu_issue_ctrl: RTL and testbench

//   Issue/writeback controller wrapped around the 4-bit registered ALU. Accepts packed
//   8-bit instructions over a valid/ready handshake, reads operands from a local

---
 rtl/alu_issue_ctrl.sv | 154 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue/writeback controller around a 4-bit registered ALU
// Optional divide-by-zero guard: define ALU_ISSUE_DIV_GUARD_EN.
// Instruction: [7:6] op (00 ADD, 01 SUB, 10 MUL, 11 DIV), [5:4] rd, [3:2] rs, [1:0] rt.
// Sequence per instruction: IDLE (accept) -> EXEC (ALU samples operands) -> WB (write back).
module alu_issue_ctrl #(
  parameter int DATA_W     = 4,
  parameter int REG_ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [7:0]            instr,
  input  logic                  ld_en,
  input  logic [REG_ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0]     ld_data,
  output logic [1:0]            alu_arithmetic_mux,
  output logic [DATA_W-1:0]     rs,
  output logic [DATA_W-1:0]     rt,
  input  logic [DATA_W-1:0]     alu_out,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  div_zero,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int NREG = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       regs_q [NREG];
  logic [REG_ADDR_W-1:0]   rd_q;
  logic [1:0]              mux_q;
  logic [DATA_W-1:0]       rs_q, rt_q;
  logic                    wb_valid_q;
  logic [REG_ADDR_W-1:0]   wb_addr_q;
  logic [DATA_W-1:0]       wb_data_q;
  logic [DATA_W-1:0]       wb_value;
  logic                    accept;

  // Instruction fields; the encoding is fixed at 2 bits per register index.
  logic [REG_ADDR_W-1:0]   f_rd, f_rs, f_rt;
  assign f_rd   = REG_ADDR_W'(instr[5:4]);
  assign f_rs   = REG_ADDR_W'(instr[3:2]);
  assign f_rt   = REG_ADDR_W'(instr[1:0]);
  assign accept = instr_valid && instr_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: fixed three-step walk, leaving IDLE only on a handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: only IDLE can take a new instruction.
  always_comb begin
    instr_ready = (state_q == S_IDLE);
  end

  // Writeback value; the ALU's mux/rt registers still hold the instruction during WB.
`ifdef ALU_ISSUE_DIV_GUARD_EN
  logic div_zero_d;
  always_comb begin
    wb_value   = alu_out;
    div_zero_d = 1'b0;
    if (mux_q == 2'b11 && rt_q == '0) begin
      wb_value   = '1;
      div_zero_d = 1'b1;
    end
  end
`else
  always_comb begin
    wb_value = alu_out;
  end
`endif

  // Operand capture at accept; reads see the register file before any same-edge write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rs_q  <= '0;
      rt_q  <= '0;
      mux_q <= '0;
      rd_q  <= '0;
    end else if (accept) begin
      rs_q  <= regs_q[f_rs];
      rt_q  <= regs_q[f_rt];
      mux_q <= instr[7:6];
      rd_q  <= f_rd;
    end
  end

  // Register file: direct loads in any state, WB write placed last so it wins a collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      if (ld_en) regs_q[ld_addr] <= ld_data;
      if (state_q == S_WB) regs_q[rd_q] <= wb_value;
    end
  end

  // Writeback report: a single-cycle strobe following the WB cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= (state_q == S_WB);
      if (state_q == S_WB) begin
        wb_addr_q <= rd_q;
        wb_data_q <= wb_value;
      end
    end
  end

`ifdef ALU_ISSUE_DIV_GUARD_EN
  logic div_zero_q;
  // Divide-by-zero flag travels alongside the writeback strobe.
  always_ff @(posedge clk) begin
    if (!reset) div_zero_q <= 1'b0;
    else        div_zero_q <= (state_q == S_WB) && div_zero_d;
  end
  assign div_zero = div_zero_q;
`else
  assign div_zero = 1'b0;
`endif

  assign alu_arithmetic_mux = mux_q;
  assign rs                 = rs_q;
  assign rt                 = rt_q;
  assign wb_valid           = wb_valid_q;
  assign wb_addr            = wb_addr_q;
  assign wb_data            = wb_data_q;
  assign dbg_data           = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] instr = 8'h00;
  logic       ld_en = 1'b0;
  logic [1:0] ld_addr = 2'd0;
  logic [3:0] ld_data = 4'd0;
  logic [1:0] alu_arithmetic_mux;
  logic [3:0] rs, rt;
  logic [3:0] alu_out = 4'd0;
  logic       wb_valid;
  logic [1:0] wb_addr;
  logic [3:0] wb_data;
  logic       div_zero;
  logic [1:0] dbg_addr = 2'd0;
  logic [3:0] dbg_data;

  int tests = 0;
  int fails = 0;

  alu_issue_ctrl #(.DATA_W(4), .REG_ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_arithmetic_mux(alu_arithmetic_mux), .rs(rs), .rt(rt), .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .div_zero(div_zero),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Environment: the registered 4-bit ALU; a zero divisor yields 0.
  always @(posedge clk) begin
    case (alu_arithmetic_mux)
      2'd0: alu_out <= 4'((int'(rs) + int'(rt)) % 16);
      2'd1: alu_out <= 4'((int'(rs) - int'(rt) + 16) % 16);
      2'd2: alu_out <= 4'((int'(rs) * int'(rt)) % 16);
      default: alu_out <= (rt == 4'd0) ? 4'd0 : 4'(int'(rs) / int'(rt));
    endcase
  end

`ifdef ALU_ISSUE_DIV_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // Reference model state: plain array of register values.
  int mregs [4];

  function automatic int ref_result(input int op, input int a, input int b);
    case (op)
      0: return (a + b) % 16;
      1: return (a - b + 16) % 16;
      2: return (a * b) % 16;
      default: begin
        if (b == 0) return GUARD ? 15 : 0;
        return a / b;
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) mregs[i] = 0;
  endtask

  task automatic load(input int a, input int d);
    ld_en = 1'b1;
    ld_addr = 2'(a);
    ld_data = 4'(d);
    tick();
    ld_en = 1'b0;
    mregs[a] = d;
  endtask

  // Issue one instruction from IDLE, optionally loading a register during the WB cycle.
  task automatic run_instr(input logic [7:0] ins, input bit wb_ld, input int la, input int ldv,
                           output int a, output int d, output int dz);
    instr = ins;
    instr_valid = 1'b1;
    chk("ready_before_accept", int'(instr_ready), 1);
    tick();
    instr = 8'($urandom);
    chk("ready_exec", int'(instr_ready), 0);
    chk("wb_valid_exec", int'(wb_valid), 0);
    tick();
    chk("ready_wb", int'(instr_ready), 0);
    chk("wb_valid_wb", int'(wb_valid), 0);
    if (wb_ld) begin
      ld_en = 1'b1;
      ld_addr = 2'(la);
      ld_data = 4'(ldv);
    end
    tick();
    ld_en = 1'b0;
    instr_valid = 1'b0;
    chk("wb_valid_pulse", int'(wb_valid), 1);
    chk("ready_after_wb", int'(instr_ready), 1);
    a = int'(wb_addr);
    d = int'(wb_data);
    dz = int'(div_zero);
    tick();
    chk("wb_valid_one_cycle", int'(wb_valid), 0);
  endtask

  function automatic int peek(input int a);
    return 0;
  endfunction

  typedef struct {
    int         r1, r2;
    logic [7:0] ins;
    int         exp_addr, exp_data, exp_dz;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int a, d, dz, op, rd, rsi, rti, exp, la, lv;
    bit wl;

    vecs[0] = '{5, 3, 8'h06, 0, 8, 0};
    vecs[1] = '{3, 5, 8'h76, 3, 14, 0};
    vecs[2] = '{7, 3, 8'hB6, 3, 5, 0};
    vecs[3] = '{9, 2, 8'hF6, 3, 4, 0};
    vecs[4] = '{15, 3, 8'h16, 1, 2, 0};
    vecs[5] = '{9, 0, 8'hC6, 0, GUARD ? 15 : 0, GUARD ? 1 : 0};

    do_reset();
    // Reset state
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk("reset_reg", int'(dbg_data), 0);
    end
    chk("reset_ready", int'(instr_ready), 1);
    chk("reset_wb_valid", int'(wb_valid), 0);
    chk("reset_mux", int'(alu_arithmetic_mux), 0);
    chk("reset_rs_rt", int'({rs, rt}), 0);

    // Directed table
    foreach (vecs[i]) begin
      load(1, vecs[i].r1);
      load(2, vecs[i].r2);
      run_instr(vecs[i].ins, 1'b0, 0, 0, a, d, dz);
      chk("vec_wb_addr", a, vecs[i].exp_addr);
      chk("vec_wb_data", d, vecs[i].exp_data);
      chk("vec_div_zero", dz, vecs[i].exp_dz);
      dbg_addr = 2'(vecs[i].exp_addr);
      #1;
      chk("vec_reg_written", int'(dbg_data), vecs[i].exp_data);
      mregs[vecs[i].exp_addr] = vecs[i].exp_data;
    end

    // Same-edge load to a source register at accept is not seen by that instruction
    load(1, 5);
    load(2, 3);
    instr = 8'h06;
    instr_valid = 1'b1;
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 4'd0;
    tick();
    ld_en = 1'b0; instr_valid = 1'b0;
    tick();
    tick();
    chk("rbw_wb_data", int'(wb_data), 8);
    dbg_addr = 2'd1;
    #1;
    chk("rbw_r1_loaded", int'(dbg_data), 0);
    tick();

    // Load collides with WB on the same address: WB wins
    load(1, 5);
    load(2, 3);
    run_instr(8'h06, 1'b1, 0, 1, a, d, dz);
    dbg_addr = 2'd0;
    #1;
    chk("collide_same_wb_wins", int'(dbg_data), 8);
    // Different addresses: both writes land
    run_instr(8'h26, 1'b1, 3, 9, a, d, dz);
    dbg_addr = 2'd2;
    #1;
    chk("collide_diff_wb", int'(dbg_data), 8);
    dbg_addr = 2'd3;
    #1;
    chk("collide_diff_ld", int'(dbg_data), 9);

    // Back-to-back with instr_valid held high
    instr = 8'h06;
    instr_valid = 1'b1;
    #1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      chk("b2b_ready", int'(instr_ready), (n % 3 == 0) ? 1 : 0);
      chk("b2b_wb_valid", int'(wb_valid), (n % 3 == 0) ? 1 : 0);
    end
    instr_valid = 1'b0;
    tick();
    tick();
    tick();

    // Reset during EXEC aborts the instruction
    instr = 8'h06;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_wb", int'(wb_valid), 0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk("abort_reg_zero", int'(dbg_data), 0);
      mregs[i] = 0;
    end
    chk("abort_ready", int'(instr_ready), 1);

    // Randomized instructions against the reference model
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 1) == 1) load(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) load(int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(0, 15)));
      instr = 8'($urandom);
      op  = int'(instr[7:6]);
      rd  = int'(instr[5:4]);
      rsi = int'(instr[3:2]);
      rti = int'(instr[1:0]);
      exp = ref_result(op, mregs[rsi], mregs[rti]);
      wl = ($urandom_range(0, 2) == 0);
      la = int'($urandom_range(0, 3));
      lv = int'($urandom_range(0, 15));
      run_instr(instr, wl, la, lv, a, d, dz);
      chk("rnd_wb_addr", a, rd);
      chk("rnd_wb_data", d, exp);
      chk("rnd_div_zero", dz, (GUARD && op == 3 && mregs[rti] == 0) ? 1 : 0);
      if (wl) mregs[la] = lv;
      mregs[rd] = exp;
      for (int i = 0; i < 4; i++) begin
        dbg_addr = 2'(i);
        #1;
        chk("rnd_regfile", int'(dbg_data), mregs[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case the sequence above stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
